// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and slave FSM state type for the SRAM slave.
// AHBL_SLV_ERR_EN adds the two-cycle ERROR response states.
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
`ifdef AHBL_SLV_ERR_EN
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
`else
    ST_LAST = 3'd2
`endif
  } state_e;

endpackage

// File: rtl/ahbl_byte_lanes.sv
// Byte-lane enable decode from transfer size and low address bits.
module ahbl_byte_lanes
  import ahbl_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] lanes_o
);

  always_comb begin
    lanes_o = '0;
    case (size_i)
      HSIZE_BYTE: lanes_o[addr_i] = 1'b1;
      HSIZE_HALF: lanes_o = addr_i[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lanes_o = '1;
      default:    lanes_o = '0;
    endcase
  end

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite slave in front of a 2**AW x 32 SRAM with programmable wait states.
// Define AHBL_SLV_ERR_EN to answer out-of-range / oversized transfers with ERROR.
module ahbl_sram_slave
  import ahbl_pkg::*;
#(
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned REGION_BITS = 24
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lo_q, lo_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d;

  logic [31:0]   mem_q [2**AW];
  logic [3:0]    lanes;
  logic          accept;
  logic          phase_free;
  logic          commit;

  assign accept = HSEL & HTRANS[1] & HREADY;

  // Address phases are only sampled in states that drive HREADYOUT high.
  assign phase_free = (state_q == ST_IDLE) || (state_q == ST_LAST)
`ifdef AHBL_SLV_ERR_EN
                   || (state_q == ST_ERR2)
`endif
                   ;

`ifdef AHBL_SLV_ERR_EN
  localparam logic [63:0] RANGE_MASK64 =
    ((64'd1 << REGION_BITS) - 64'd1) & ~((64'd1 << (AW + 2)) - 64'd1);
  localparam logic [31:0] RANGE_MASK = RANGE_MASK64[31:0];

  logic err_req;
  logic hresp_d;
  assign err_req = (|(HADDR & RANGE_MASK)) | (HSIZE > HSIZE_WORD);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lo_d      = lo_q;
    size_d    = size_q;
    write_d   = write_q;
    HREADYOUT = 1'b1;
`ifdef AHBL_SLV_ERR_EN
    hresp_d   = HRESP_OKAY;
`endif

    case (state_q)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q <= 4'd1) begin
          state_d = ST_LAST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef AHBL_SLV_ERR_EN
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        hresp_d   = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: hresp_d = HRESP_ERROR;
`endif
      default: ;
    endcase

    if (phase_free) begin
      if (accept) begin
        idx_d   = HADDR[AW+1:2];
        lo_d    = HADDR[1:0];
        size_d  = HSIZE;
        write_d = HWRITE;
`ifdef AHBL_SLV_ERR_EN
        if (err_req) begin
          state_d = ST_ERR1;
          cnt_d   = '0;
        end else
`endif
        if (WAIT_STATES == 0) begin
          state_d = ST_LAST;
          cnt_d   = '0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = WS_CNT;
        end
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lo_q    <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  ahbl_byte_lanes u_lanes (
    .size_i  (size_q),
    .addr_i  (lo_q),
    .lanes_o (lanes)
  );

  // A reset on the completing edge abandons the write.
  assign commit = (state_q == ST_LAST) && write_q && !HRESET;

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lanes[b]) mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA = ((state_q == ST_LAST) && !write_q) ? mem_q[idx_q] : '0;

`ifdef AHBL_SLV_ERR_EN
  assign HRESP = hresp_d;
`else
  assign HRESP = HRESP_OKAY;
`endif

  logic unused_in;
  assign unused_in = ^{HADDR[31:AW+2], HTRANS[0]};

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed self-checking bench for ahbl_sram_slave (AW=10, WAIT_STATES=1).
module tb_ahbl_sram_slave;
  import ahbl_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  int checks   = 0;
  int failures = 0;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahbl_sram_slave #(.AW(10), .WAIT_STATES(1), .REGION_BITS(24)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Single non-pipelined transfer, called with the bus idle and HREADYOUT high.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output int waits, output logic resp, output logic tmo);
    HSEL   = 1'b1;
    HTRANS = HTRANS_NONSEQ;
    HADDR  = addr;
    HSIZE  = size;
    HWRITE = wr;
    step();
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HWDATA = wdata;
    waits  = 0;
    resp   = 1'b0;
    tmo    = 1'b0;
    while (HREADYOUT !== 1'b1 && waits < 20) begin
      resp |= HRESP;
      waits++;
      step();
    end
    if (HREADYOUT !== 1'b1) begin
      tmo = 1'b1;
      failures++;
      $error("FAIL xfer_timeout addr=%h waits=%0d", addr, waits);
    end
    resp |= HRESP;
    rdata = HRDATA;
    step();
  endtask

  logic [31:0] rd;
  int          w;
  logic        rsp;
  logic        to;

  initial begin
    HRESET = 1'b1;
    HSEL   = 1'b0;
    HADDR  = '0;
    HTRANS = HTRANS_IDLE;
    HSIZE  = HSIZE_WORD;
    HWRITE = 1'b0;
    HWDATA = '0;
    step();
    step();
    chk("rst_hreadyout", HREADYOUT, 1'b1);
    chk("rst_hresp", HRESP, 1'b0);
    chk("rst_hrdata", HRDATA, 32'h0);
    HRESET = 1'b0;
    step();

    // Basic word write then read with one wait state each.
    xfer(1'b1, 32'h4, HSIZE_WORD, 32'h12345678, rd, w, rsp, to);
    chk("wr4_waits", w, 1);
    chk("wr4_resp", rsp, 1'b0);
    chk("wr4_hrdata_zero", rd, 32'h0);
    chk("wr4_timeout", to, 1'b0);
    xfer(1'b0, 32'h4, HSIZE_WORD, 32'h0, rd, w, rsp, to);
    chk("rd4_data", rd, 32'h12345678);
    chk("rd4_waits", w, 1);
    chk("rd4_resp", rsp, 1'b0);

    // Byte and halfword lane writes.
    xfer(1'b1, 32'h8, HSIZE_WORD, 32'hFFFFFFFF, rd, w, rsp, to);
    xfer(1'b1, 32'h9, HSIZE_BYTE, 32'h0000AB00, rd, w, rsp, to);
    xfer(1'b0, 32'h8, HSIZE_WORD, 32'h0, rd, w, rsp, to);
    chk("rd8_after_byte", rd, 32'hFFFFABFF);
    xfer(1'b1, 32'hA, HSIZE_HALF, 32'h12340000, rd, w, rsp, to);
    xfer(1'b0, 32'h8, HSIZE_WORD, 32'h0, rd, w, rsp, to);
    chk("rd8_after_half", rd, 32'h1234ABFF);
    xfer(1'b1, 32'h8, HSIZE_BYTE, 32'h00000011, rd, w, rsp, to);
    xfer(1'b0, 32'hB, HSIZE_BYTE, 32'h0, rd, w, rsp, to);
    chk("rd8_after_byte0", rd, 32'h1234AB11);

    // Back-to-back write then read of misaligned word 0x1, no idle cycle.
    HSEL   = 1'b1;
    HTRANS = HTRANS_NONSEQ;
    HADDR  = 32'h1;
    HSIZE  = HSIZE_WORD;
    HWRITE = 1'b1;
    step();
    chk("b2b_wr_wait", HREADYOUT, 1'b0);
    HWDATA = 32'h3;
    HWRITE = 1'b0;
    step();
    chk("b2b_wr_last", HREADYOUT, 1'b1);
    step();
    chk("b2b_rd_accepted", HREADYOUT, 1'b0);
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    step();
    chk("b2b_rd_ready", HREADYOUT, 1'b1);
    chk("b2b_rd_data", HRDATA, 32'h3);
    step();
    chk("b2b_idle_hrdata", HRDATA, 32'h0);

    // IDLE / BUSY / deselected cycles must not touch memory.
    HWDATA = 32'hBAD0BAD0;
    HADDR  = 32'h4;
    HWRITE = 1'b1;
    HSEL   = 1'b1;
    HTRANS = HTRANS_IDLE;
    step();
    chk("idle_ready", HREADYOUT, 1'b1);
    HTRANS = HTRANS_BUSY;
    step();
    chk("busy_ready", HREADYOUT, 1'b1);
    chk("busy_resp", HRESP, 1'b0);
    HSEL   = 1'b0;
    HTRANS = HTRANS_NONSEQ;
    step();
    chk("nosel_ready", HREADYOUT, 1'b1);
    HTRANS = HTRANS_IDLE;
    step();
    chk("nosel_ready2", HREADYOUT, 1'b1);
    xfer(1'b0, 32'h4, HSIZE_WORD, 32'h0, rd, w, rsp, to);
    chk("rd4_unchanged", rd, 32'h12345678);

    // Reset during the wait state abandons the write.
    xfer(1'b1, 32'h10, HSIZE_WORD, 32'h11112222, rd, w, rsp, to);
    HSEL   = 1'b1;
    HTRANS = HTRANS_NONSEQ;
    HADDR  = 32'h10;
    HWRITE = 1'b1;
    step();
    chk("rst_mid_wait", HREADYOUT, 1'b0);
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HWDATA = 32'hDEADBEEF;
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    chk("rst_mid_ready", HREADYOUT, 1'b1);
    chk("rst_mid_resp", HRESP, 1'b0);
    step();
    step();
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, w, rsp, to);
    chk("rd10_pre_reset", rd, 32'h11112222);

`ifdef AHBL_SLV_ERR_EN
    HSEL   = 1'b1;
    HTRANS = HTRANS_NONSEQ;
    HADDR  = 32'h00001000;
    HSIZE  = HSIZE_WORD;
    HWRITE = 1'b1;
    step();
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HWDATA = 32'hCAFEF00D;
    chk("err1_ready", HREADYOUT, 1'b0);
    chk("err1_resp", HRESP, 1'b1);
    step();
    chk("err2_ready", HREADYOUT, 1'b1);
    chk("err2_resp", HRESP, 1'b1);
    chk("err2_hrdata", HRDATA, 32'h0);
    step();
    chk("err_done_resp", HRESP, 1'b0);
    xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, w, rsp, to);
    chk("rd0_no_err_write", rd, 32'h3);
    xfer(1'b1, 32'h0, 3'd3, 32'h55555555, rd, w, rsp, to);
    chk("size3_err_resp", rsp, 1'b1);
    chk("size3_err_waits", w, 1);
`else
    xfer(1'b1, 32'h00001000, HSIZE_WORD, 32'hCAFEF00D, rd, w, rsp, to);
    chk("alias_wr_resp", rsp, 1'b0);
    chk("alias_wr_waits", w, 1);
    xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, w, rsp, to);
    chk("alias_rd0", rd, 32'hCAFEF00D);
    xfer(1'b1, 32'h0, 3'd3, 32'h55555555, rd, w, rsp, to);
    xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, w, rsp, to);
    chk("size3_no_lanes", rd, 32'hCAFEF00D);
`endif
    chk("final_timeout", to, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
